// File: rtl/riscv_pkg.sv
// Shared constants and types for the riscv processing unit.
// Register addresses are sized for the largest supported file; modules cast to their own width.
package riscv_pkg;

  localparam int unsigned REG_ADDR_BITS = 5;

  typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;
  localparam reg_addr_t LINK_1   = 5'd1;

  localparam int unsigned REGFILE_MAX_RD_PORTS = 4;

endpackage

// File: rtl/riscv_pu_regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// An issue sets its destination and an effective write clears it; the set wins a same-cycle collision.
module riscv_pu_regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  set_valid,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic [NUM_REGS-1:0]   clr_vec,
  output logic [NUM_REGS-1:0]   busy_clr_c,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask_c;
  logic [NUM_REGS-1:0] busy_next_c;

  // x0 can never be pending; the set is masked here rather than at the issue source.
  always_comb begin
    set_mask_c = '0;
    if (set_valid && (set_addr != ADDR_WIDTH'(ZERO_REG))) begin
      set_mask_c[set_addr] = 1'b1;
    end
  end

  // Clears apply first, so an older writeback cannot retire a younger issue's claim.
  always_comb begin
    busy_clr_c  = busy_q & ~clr_vec;
    busy_next_c = busy_clr_c | set_mask_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else if (enable) begin
      busy_q <= busy_next_c;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/riscv_pu_regfile_mp.sv
// Multi-port integer register file with hardwired x0, same-cycle write bypass,
// RAS link restore on write port 0 and a pending-write scoreboard.
module riscv_pu_regfile_mp
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_WIDTH   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_WR_PORTS = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               i_stall_rd,
  input  logic                               i_stall_wr,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] o_rd_data,
  output logic [NUM_RD_PORTS-1:0]            o_rd_busy,
  input  logic [NUM_WR_PORTS-1:0]            i_wr_en,
  input  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] i_wr_data,
  input  logic                               i_ras_read,
  input  logic [DATA_WIDTH-1:0]              i_ras_data,
  input  logic                               i_issue_valid,
  input  logic [ADDR_WIDTH-1:0]              i_issue_addr,
  output logic [NUM_REGS-1:0]                o_busy_vec
);

  if ((NUM_RD_PORTS < 1) || (NUM_RD_PORTS > REGFILE_MAX_RD_PORTS)) begin : g_bad_rd_ports
    $error("riscv_pu_regfile_mp: NUM_RD_PORTS out of range");
  end

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  logic [NUM_WR_PORTS-1:0] wr_eff_c;
  logic [ADDR_WIDTH-1:0]   wr_addr_c [NUM_WR_PORTS];
  logic [DATA_WIDTH-1:0]   wr_data_c [NUM_WR_PORTS];
  logic [NUM_REGS-1:0]     clr_vec_c;
  logic [NUM_REGS-1:0]     busy_clr_c;

  // Effective write ports; a RAS restore takes over port 0 and targets the link register.
  always_comb begin
    for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
      wr_eff_c[w]  = i_wr_en[w] && !i_stall_wr && enable;
      wr_addr_c[w] = i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data_c[w] = i_wr_data[w*DATA_WIDTH +: DATA_WIDTH];
    end
    if (i_ras_read) begin
      wr_eff_c[0]  = !i_stall_wr && enable;
      wr_addr_c[0] = ADDR_WIDTH'(LINK_1);
      wr_data_c[0] = i_ras_data;
    end
  end

  always_comb begin
    clr_vec_c = '0;
    for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_eff_c[w]) begin
        clr_vec_c[wr_addr_c[w]] = 1'b1;
      end
    end
  end

  // Storage has no reset; later ports overwrite earlier ones on an address collision.
  always_ff @(posedge clk) begin
    for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_eff_c[w] && (wr_addr_c[w] != ADDR_WIDTH'(ZERO_REG))) begin
        mem[wr_addr_c[w]] <= wr_data_c[w];
      end
    end
  end

  riscv_pu_regfile_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .set_valid  (i_issue_valid),
    .set_addr   (i_issue_addr),
    .clr_vec    (clr_vec_c),
    .busy_clr_c (busy_clr_c),
    .busy_vec   (o_busy_vec)
  );

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [DATA_WIDTH-1:0] data_c;
    logic                  busy_c;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;

    assign addr_c = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Bypass from the highest matching write port; x0 always reads as an idle zero.
    always_comb begin
      data_c = mem[addr_c];
      busy_c = busy_clr_c[addr_c];
      for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_eff_c[w] && (wr_addr_c[w] == addr_c)) begin
          data_c = wr_data_c[w];
        end
      end
      if (addr_c == ADDR_WIDTH'(ZERO_REG)) begin
        data_c = '0;
        busy_c = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else if (enable && !i_stall_rd) begin
        data_q <= data_c;
        busy_q <= busy_c;
      end
    end

    assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign o_rd_busy[k]                          = busy_q;
  end

endmodule

// File: tb/tb_riscv_pu_regfile_mp.sv
// Directed bench for riscv_pu_regfile_mp (2 read, 2 write ports) with a cycle-level reference model.
module tb_riscv_pu_regfile_mp;

  localparam int unsigned DW = 64;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned RP = 2;
  localparam int unsigned WP = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b1;
  logic             i_stall_rd = 1'b0;
  logic             i_stall_wr = 1'b0;
  logic [RP*AW-1:0] i_rd_addr = '0;
  logic [RP*DW-1:0] o_rd_data;
  logic [RP-1:0]    o_rd_busy;
  logic [WP-1:0]    i_wr_en = '0;
  logic [WP*AW-1:0] i_wr_addr = '0;
  logic [WP*DW-1:0] i_wr_data = '0;
  logic             i_ras_read = 1'b0;
  logic [DW-1:0]    i_ras_data = '0;
  logic             i_issue_valid = 1'b0;
  logic [AW-1:0]    i_issue_addr = '0;
  logic [NR-1:0]    o_busy_vec;

  int n_cmp = 0;
  int n_fail = 0;

  riscv_pu_regfile_mp #(
    .DATA_WIDTH   (DW),
    .NUM_REGS     (NR),
    .ADDR_WIDTH   (AW),
    .NUM_RD_PORTS (RP),
    .NUM_WR_PORTS (WP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .i_stall_rd    (i_stall_rd),
    .i_stall_wr    (i_stall_wr),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_rd_busy     (o_rd_busy),
    .i_wr_en       (i_wr_en),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .i_ras_read    (i_ras_read),
    .i_ras_data    (i_ras_data),
    .i_issue_valid (i_issue_valid),
    .i_issue_addr  (i_issue_addr),
    .o_busy_vec    (o_busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers, pending set, and the last sampled read results.
  logic [DW-1:0] m_mem [NR];
  logic [NR-1:0] m_busy = '0;
  logic [DW-1:0] m_rd [RP];
  logic [RP-1:0] m_rd_busy = '0;

  initial begin
    for (int r = 0; r < NR; r++) m_mem[r] = '0;
    for (int k = 0; k < RP; k++) m_rd[k] = '0;
  end

  always @(posedge clk or posedge reset) begin : model
    int            wa [WP];
    logic [DW-1:0] wd [WP];
    bit            we [WP];
    bit            written [NR];
    int            a;
    logic [DW-1:0] v;
    if (reset) begin
      for (int k = 0; k < RP; k++) m_rd[k] <= '0;
      m_rd_busy <= '0;
      m_busy    <= '0;
    end else if (enable) begin
      for (int r = 0; r < NR; r++) written[r] = 1'b0;
      for (int w = 0; w < WP; w++) begin
        we[w] = i_wr_en[w] && !i_stall_wr;
        wa[w] = int'(i_wr_addr[w*AW +: AW]);
        wd[w] = i_wr_data[w*DW +: DW];
      end
      if (i_ras_read) begin
        we[0] = !i_stall_wr;
        wa[0] = 1;
        wd[0] = i_ras_data;
      end
      for (int w = 0; w < WP; w++) if (we[w]) written[wa[w]] = 1'b1;
      if (!i_stall_rd) begin
        for (int k = 0; k < RP; k++) begin
          a = int'(i_rd_addr[k*AW +: AW]);
          v = m_mem[a];
          for (int w = 0; w < WP; w++) if (we[w] && wa[w] == a) v = wd[w];
          m_rd[k]      <= (a == 0) ? '0 : v;
          m_rd_busy[k] <= (a != 0) && m_busy[a] && !written[a];
        end
      end
      for (int w = 0; w < WP; w++) if (we[w] && wa[w] != 0) m_mem[wa[w]] <= wd[w];
      for (int r = 0; r < NR; r++) begin
        if (i_issue_valid && int'(i_issue_addr) == r && r != 0) m_busy[r] <= 1'b1;
        else if (written[r]) m_busy[r] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < RP; k++) begin
      check($sformatf("rd_data[%0d]", k), o_rd_data[k*DW +: DW], m_rd[k]);
      check($sformatf("rd_busy[%0d]", k), 64'(o_rd_busy[k]), 64'(m_rd_busy[k]));
    end
    check("busy_vec", 64'(o_busy_vec), 64'(m_busy));
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input bit en, input int a, input logic [DW-1:0] d);
    i_wr_en[p]            = en;
    i_wr_addr[p*AW +: AW] = AW'(a);
    i_wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int k, input int a);
    i_rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    i_wr_en       = '0;
    i_ras_read    = 1'b0;
    i_issue_valid = 1'b0;
    i_stall_rd    = 1'b0;
    i_stall_wr    = 1'b0;
    enable        = 1'b1;
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    logic [RP*DW-1:0] tmp;
    tmp = o_rd_data;
    return tmp[k*DW +: DW];
  endfunction

  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset_rd0", rd(0), 64'h0);
    check("reset_rd1", rd(1), 64'h0);
    check("reset_busy_vec", 64'(o_busy_vec), 64'h0);
    @(negedge clk);
    #1 reset = 1'b0;

    // Preload every register with r * 0x1111; the x0 write must be discarded.
    for (int r = 0; r < 16; r++) begin
      set_wr(0, 1'b1, r, 64'(r) * 64'h1111);
      set_wr(1, 1'b1, r + 16, 64'(r + 16) * 64'h1111);
      cyc();
    end
    idle();

    // Same-cycle bypass, then the array copy one cycle later.
    set_wr(0, 1'b1, 5, 64'hDEAD_BEEF);
    set_rd(0, 5);
    set_rd(1, 4);
    cyc();
    check("bypass_x5", rd(0), 64'hDEAD_BEEF);
    check("array_x4", rd(1), 64'h4444);
    idle();
    set_rd(1, 5);
    cyc();
    check("array_x5", rd(1), 64'hDEAD_BEEF);

    // Higher write port wins on the same address.
    set_wr(0, 1'b1, 7, 64'h11);
    set_wr(1, 1'b1, 7, 64'h22);
    cyc();
    idle();
    set_rd(0, 7);
    cyc();
    check("dual_wr_x7", rd(0), 64'h22);

    // x0 stays zero, even through the bypass path.
    set_wr(0, 1'b1, 0, 64'hFF);
    set_rd(0, 0);
    cyc();
    check("x0_bypass", rd(0), 64'h0);
    idle();
    cyc();
    check("x0_array", rd(0), 64'h0);

    // RAS restore steals port 0 from its x9 write.
    i_ras_read = 1'b1;
    i_ras_data = 64'h8000_0040;
    set_wr(0, 1'b1, 9, 64'h1234);
    cyc();
    idle();
    set_rd(0, 1);
    set_rd(1, 9);
    cyc();
    check("ras_x1", rd(0), 64'h8000_0040);
    check("ras_x9_kept", rd(1), 64'h9999);

    // Scoreboard set, blocked clear, set-beats-clear, clear.
    i_issue_valid = 1'b1;
    i_issue_addr  = 5'd3;
    set_rd(0, 3);
    cyc();
    check("sb_issue_x3", 64'(o_busy_vec[3]), 64'h1);
    check("sb_rd_busy_pre_set", 64'(o_rd_busy[0]), 64'h0);
    idle();
    cyc();
    check("sb_rd_busy_x3", 64'(o_rd_busy[0]), 64'h1);
    set_wr(0, 1'b1, 3, 64'h3333_0001);
    i_stall_wr = 1'b1;
    cyc();
    check("sb_stall_wr_keeps", 64'(o_busy_vec[3]), 64'h1);
    check("stall_wr_no_write", rd(0), 64'h3333);
    i_stall_wr    = 1'b0;
    set_wr(0, 1'b1, 3, 64'h33);
    i_issue_valid = 1'b1;
    i_issue_addr  = 5'd3;
    cyc();
    check("sb_set_wins", 64'(o_busy_vec[3]), 64'h1);
    check("sb_rd_busy_after_clr", 64'(o_rd_busy[0]), 64'h0);
    check("bypass_x3", rd(0), 64'h33);
    idle();
    set_wr(0, 1'b1, 3, 64'h34);
    cyc();
    check("sb_clear_x3", 64'(o_busy_vec[3]), 64'h0);
    idle();
    i_issue_valid = 1'b1;
    i_issue_addr  = 5'd0;
    cyc();
    check("sb_x0_never_busy", 64'(o_busy_vec[0]), 64'h0);
    idle();

    // Read stall holds the old value while x4 changes underneath.
    set_rd(0, 4);
    cyc();
    check("pre_stall_x4", rd(0), 64'h4444);
    i_stall_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_wr(0, 1'b1, 4, 64'h5A5A_0000 + 64'(i));
      cyc();
      check($sformatf("stall_hold_%0d", i), rd(0), 64'h4444);
    end
    idle();
    cyc();
    check("stall_release_x4", rd(0), 64'h5A5A_0002);

    // Global enable low freezes everything.
    enable        = 1'b0;
    set_wr(0, 1'b1, 10, 64'hFFFF);
    i_issue_valid = 1'b1;
    i_issue_addr  = 5'd11;
    set_rd(0, 10);
    cyc();
    check("en_low_hold_rd", rd(0), 64'h5A5A_0002);
    check("en_low_no_issue", 64'(o_busy_vec[11]), 64'h0);
    idle();
    cyc();
    check("en_low_no_write", rd(0), 64'hAAAA);

    // Asynchronous reset mid-cycle clears outputs but not storage.
    i_issue_valid = 1'b1;
    i_issue_addr  = 5'd12;
    set_rd(0, 12);
    cyc();
    idle();
    cyc();
    check("pre_reset_busy", 64'(o_rd_busy[0]), 64'h1);
    check("pre_reset_rd", rd(0), 64'hCCCC);
    #2 reset = 1'b1;
    #1;
    check("async_reset_rd0", rd(0), 64'h0);
    check("async_reset_rd_busy", 64'(o_rd_busy), 64'h0);
    check("async_reset_busy_vec", 64'(o_busy_vec), 64'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    cyc();
    check("post_reset_x12", rd(0), 64'hCCCC);
    check("post_reset_not_busy", 64'(o_rd_busy[0]), 64'h0);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
